// File: rtl/seq_101x_stream_gen_pkg.sv
// Shared definitions for the 101X stream generator and the sequence detectors.
// Holds the state encodings, default word width and length-field width.
package seq_det_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int LEN_W         = 5;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // A zero length field stands for a full 16-bit word.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(16) : len;
  endfunction

endpackage

// File: rtl/seq_101x_stream_gen_if.sv
// Load/stream bundle of the 101X stream generator; master drives requests,
// slave is the generator.
interface seq_101x_stream_gen_if #(parameter int WIDTH = seq_det_pkg::DEFAULT_WIDTH);
  import seq_det_pkg::*;

  logic             load;
  logic [WIDTH-1:0] data;
  logic [LEN_W-1:0] len;
  logic             loop;
  logic             abort;
  logic             ready;
  logic             out;
  logic             out_vld;
  logic             done;
  logic             exp_det;
  logic [1:0]       cs;
  logic [1:0]       ns;

  modport master (
    output load, data, len, loop, abort,
    input  ready, out, out_vld, done, exp_det, cs, ns
  );

  modport slave (
    input  load, data, len, loop, abort,
    output ready, out, out_vld, done, exp_det, cs, ns
  );

endinterface

// File: rtl/seq_101x_stream_gen_bit_cnt_dn.sv
// Loadable down-counter tracking the remaining bits of the current pass.
// Saturates at zero; zero flag is combinational.
module bit_cnt_dn
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic [LEN_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && !zero)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_101x_stream_gen.sv
// Serializes a held word MSB-first (optionally looping) and raises a Mealy
// flag whenever the emitted stream matches an overlapping 101X pattern.
module seq_101x_stream_gen
  import seq_det_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic                  clk,
  input  logic                  rst,
  seq_101x_stream_gen_if.slave  bus
);

  logic [1:0]       cs_q;
  logic [1:0]       ns_d;
  logic [WIDTH-1:0] held_word;
  logic [WIDTH-1:0] shift_reg;
  logic [LEN_W-1:0] held_len;
  logic [LEN_W-1:0] load_len;
  logic [LEN_W-1:0] cnt_val;
  logic [LEN_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             start_load;
  logic             start_loop;
  logic             out_vld;
  logic             out_bit;
  logic [2:0]       history;

  // The first bit to send sits at the shift register MSB.
  function automatic logic [WIDTH-1:0] align_word(input logic [WIDTH-1:0] w,
                                                  input logic [LEN_W-1:0] n);
    return w << (WIDTH - int'(n));
  endfunction

  assign load_len     = eff_len(bus.len);
  assign start_load   = (cs_q == ST_IDLE) && bus.load;
  assign start_loop   = (cs_q == ST_DONE) && bus.loop && !bus.abort;
  assign cnt_load_val = start_load ? (load_len - 1'b1) : (held_len - 1'b1);

  bit_cnt_dn u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_load || start_loop),
    .load_val (cnt_load_val),
    .dec      (out_vld),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  // Abort has priority over both the end-of-word and the loop decisions.
  always_comb begin
    ns_d = ST_IDLE;
    if (!rst) begin
      case (cs_q)
        ST_IDLE:  ns_d = bus.load ? ST_SHIFT : ST_IDLE;
        ST_SHIFT: ns_d = bus.abort ? ST_IDLE : (cnt_zero ? ST_DONE : ST_SHIFT);
        ST_DONE:  ns_d = (!bus.abort && bus.loop) ? ST_SHIFT : ST_IDLE;
        default:  ns_d = ST_IDLE;
      endcase
    end
  end

  // History survives loop passes and is only cleared by a fresh load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q      <= ST_IDLE;
      held_word <= '0;
      held_len  <= '0;
      shift_reg <= '0;
      history   <= '0;
    end else begin
      cs_q <= ns_d;
      if (start_load) begin
        held_word <= bus.data;
        held_len  <= load_len;
        shift_reg <= align_word(bus.data, load_len);
        history   <= '0;
      end else if (start_loop) begin
        shift_reg <= align_word(held_word, held_len);
      end else if (out_vld) begin
        shift_reg <= shift_reg << 1;
        history   <= {history[1:0], out_bit};
      end
    end
  end

  assign out_vld     = (cs_q == ST_SHIFT);
  assign out_bit     = out_vld & shift_reg[WIDTH-1];
  assign bus.out     = out_bit;
  assign bus.out_vld = out_vld;
  assign bus.done    = (cs_q == ST_DONE);
  assign bus.ready   = (cs_q == ST_IDLE);
  assign bus.exp_det = out_vld && (history == 3'b101);
  assign bus.cs      = cs_q;
  assign bus.ns      = ns_d;

endmodule

// File: tb/tb_seq_101x_stream_gen.sv
// Bench for seq_101x_stream_gen: directed vector table, multi-cycle corner
// sequences, then random traffic against a queue-based reference model.
module tb_seq_101x_stream_gen;
  import seq_det_pkg::*;

  typedef struct {
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [4:0]  len;
    logic        loop;
    logic        abort;
    logic        chk;
    logic [6:0]  expv;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   passCount  = 0;
  int   checkCount = 0;
  vec_t vecs[$];
  logic [8:0] trace [20];

  always #5 clk = ~clk;

  seq_101x_stream_gen_if #(.WIDTH(16)) bus ();

  seq_101x_stream_gen #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Packed view: {cs, ns, ready, out, out_vld, done, exp_det}.
  function automatic logic [8:0] snap();
    return {bus.cs, bus.ns, bus.ready, bus.out, bus.out_vld, bus.done, bus.exp_det};
  endfunction

  function automatic logic [6:0] snapNoNs();
    return {bus.cs, bus.ready, bus.out, bus.out_vld, bus.done, bus.exp_det};
  endfunction

  task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] d,
                               input logic [4:0] ln, input logic lp, input logic ab);
    @(posedge clk);
    #1;
    rst       = r;
    bus.load  = ld;
    bus.data  = d;
    bus.len   = ln;
    bus.loop  = lp;
    bus.abort = ab;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  task automatic addVec(input logic r, input logic ld, input logic [15:0] d,
                        input logic [4:0] ln, input logic lp, input logic ab,
                        input logic chk, input logic [1:0] cs, input logic rdy,
                        input logic o, input logic v, input logic dn, input logic det);
    vec_t x;
    x.rst = r; x.load = ld; x.data = d; x.len = ln; x.loop = lp; x.abort = ab;
    x.chk = chk;
    x.expv = {cs, rdy, o, v, dn, det};
    vecs.push_back(x);
  endtask

  // Reference model: bits still to send this pass, word bits, emitted bits.
  bit mQ[$];
  bit mHeld[$];
  bit mEmit[$];
  bit mDone;

  function automatic logic [1:0] modelCs();
    if (mQ.size() > 0) return 2'b01;
    if (mDone)         return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [8:0] modelOutputsNoNs();
    logic vld, o, det;
    vld = (mQ.size() > 0);
    o   = vld ? mQ[0] : 1'b0;
    det = vld && (mEmit.size() >= 3) && mEmit[$-2] && !mEmit[$-1] && mEmit[$];
    return {modelCs(), 2'b00, (!vld && !mDone), o, vld, mDone, det};
  endfunction

  task automatic modelStep(input logic r, input logic ld, input logic [15:0] d,
                           input logic [4:0] ln, input logic lp, input logic ab);
    int n;
    if (r) begin
      mQ.delete(); mHeld.delete(); mEmit.delete(); mDone = 0;
    end else if (mQ.size() > 0) begin
      if (ab) mQ.delete();
      else begin
        mEmit.push_back(mQ.pop_front());
        if (mEmit.size() > 3) void'(mEmit.pop_front());
        if (mQ.size() == 0) mDone = 1;
      end
    end else if (mDone) begin
      mDone = 0;
      if (!ab && lp) mQ = mHeld;
    end else if (ld) begin
      n = (ln == 5'd0) ? 16 : int'(ln);
      mHeld.delete();
      for (int i = n - 1; i >= 0; i--) mHeld.push_back(d[i]);
      mQ = mHeld;
      mEmit.delete();
    end
  endtask

  initial begin
    logic r, ld, lp, ab;
    logic [15:0] d;
    logic [4:0] ln;
    logic [8:0] expv;
    int vldCount;
    logic orBits;

    rst = 1'b1; bus.load = 0; bus.data = '0; bus.len = '0; bus.loop = 0; bus.abort = 0;

    // Reset, then 0x000B/4 and the overlapping 1010101/7 stream.
    addVec(1, 0, 16'h0000, 5'd0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0);
    addVec(1, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0);
    addVec(0, 1, 16'h000B, 5'd4, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b01, 0, 1, 1, 0, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b01, 0, 0, 1, 0, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b01, 0, 1, 1, 0, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b01, 0, 1, 1, 0, 1);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b10, 0, 0, 0, 1, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0);
    addVec(0, 1, 16'h0055, 5'd7, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b01, 0, 1, 1, 0, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b01, 0, 0, 1, 0, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b01, 0, 1, 1, 0, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b01, 0, 0, 1, 0, 1);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b01, 0, 1, 1, 0, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b01, 0, 0, 1, 0, 1);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b01, 0, 1, 1, 0, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b10, 0, 0, 0, 1, 0);
    addVec(0, 0, 16'h0000, 5'd0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].data, vecs[i].len,
                    vecs[i].loop, vecs[i].abort);
      @(negedge clk);
      if (vecs[i].chk)
        checkOutput($sformatf("vec%0d", i), 16'(snapNoNs()), 16'(vecs[i].expv));
    end

    // Loop pass over 1010, loop dropped during the second pass.
    for (int c = 0; c < 12; c++) begin
      applyStimulus(0, c == 0, 16'h000A, 5'd4, c < 6, 0);
      @(negedge clk);
      trace[c] = snap();
    end
    checkOutput("loop_det_k4", 16'(trace[4][0]), 16'd1);
    checkOutput("loop_done_k5", 16'(trace[5][1]), 16'd1);
    checkOutput("loop_cs_k6", 16'(trace[6][8:7]), 16'(ST_SHIFT));
    checkOutput("loop_det_k6", 16'(trace[6][0]), 16'd0);
    checkOutput("loop_det_k7", 16'(trace[7][0]), 16'd1);
    checkOutput("loop_det_k8", 16'(trace[8][0]), 16'd0);
    checkOutput("loop_done_k10", 16'(trace[10][1]), 16'd1);
    checkOutput("loop_idle_k11", 16'(trace[11][8:7]), 16'(ST_IDLE));

    // Load during SHIFT ignored, then abort.
    for (int c = 0; c < 6; c++) begin
      applyStimulus(0, c <= 1, (c == 0) ? 16'h000B : 16'h0005,
                    (c == 0) ? 5'd4 : 5'd3, 0, c == 2);
      @(negedge clk);
      trace[c] = snap();
    end
    checkOutput("abort_cs_k2", 16'(trace[2][8:7]), 16'(ST_SHIFT));
    checkOutput("ignored_load_out_k2", 16'(trace[2][3]), 16'd0);
    checkOutput("abort_idle_k3", 16'({trace[3][8:7], trace[3][4]}), 16'b001);
    orBits = trace[3][1] | trace[4][1] | trace[5][1];
    checkOutput("abort_no_done", 16'(orBits), 16'd0);

    // Len=0 means a full 16-bit word.
    for (int c = 0; c < 19; c++) begin
      applyStimulus(0, c == 0, 16'h8001, 5'd0, 0, 0);
      @(negedge clk);
      trace[c] = snap();
    end
    vldCount = 0;
    orBits = 1'b0;
    for (int c = 1; c <= 17; c++) vldCount += int'(trace[c][2]);
    for (int c = 2; c <= 15; c++) orBits |= trace[c][3];
    checkOutput("len0_first", 16'(trace[1][3:2]), 16'b11);
    checkOutput("len0_last", 16'(trace[16][3:2]), 16'b11);
    checkOutput("len0_middle_zero", 16'(orBits), 16'd0);
    checkOutput("len0_vld_count", 16'(vldCount), 16'd16);
    checkOutput("len0_done_k17", 16'(trace[17][1]), 16'd1);

    // Reset mid-word.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(c == 8, c == 0, 16'h8001, 5'd0, 1, 0);
      @(negedge clk);
      trace[c] = snap();
    end
    checkOutput("rst_mid_vld_k8", 16'(trace[8][2]), 16'd1);
    checkOutput("rst_mid_idle_k9",
                16'({trace[9][8:7], trace[9][4:0]}), 16'b00_1_0000);

    // Random traffic against the reference model.
    applyStimulus(1, 0, 16'h0000, 5'd0, 0, 0);
    modelStep(1, 0, 16'h0000, 5'd0, 0, 0);
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 99) < 2);
      ld = ($urandom_range(0, 99) < 40);
      lp = ($urandom_range(0, 99) < 60);
      ab = ($urandom_range(0, 99) < 6);
      d  = 16'($urandom);
      ln = 5'($urandom_range(0, 16));
      applyStimulus(r, ld, d, ln, lp, ab);
      expv = modelOutputsNoNs();
      modelStep(r, ld, d, ln, lp, ab);
      expv[6:5] = modelCs();
      @(negedge clk);
      checkOutput($sformatf("rand%0d", c), 16'(snap()), 16'(expv));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seq_101x_stream_gen.md
SEQ_101X_STREAM_GEN -- requirements
Module: seq_101x_stream_gen

Interface
REQ-001 Parameter WIDTH, default 16, maximum serial word length in bits.
REQ-002 Clk  input  1  system clock, all state changes on rising edge.
REQ-003 Rst  input  1  synchronous active-high reset.
REQ-004 Load  input  1  request to accept Data/Len; taken only when Ready=1.
REQ-005 Data  input  WIDTH  parallel word to serialize.
REQ-006 Len  input  5  bits to send, 1..16; 0 means 16.
REQ-007 Loop  input  1  repeat the held word after Done.
REQ-008 Abort  input  1  stop transmission, no Done.
REQ-009 Ready  output  1  high only in IDLE.
REQ-010 Out  output  1  serial bit, 0 when Out_vld=0.
REQ-011 Out_vld  output  1  Out carries a stream bit this cycle.
REQ-012 Done  output  1  one-cycle end-of-word pulse.
REQ-013 Exp_det  output  1  Mealy expected-detect flag for overlapping 101X.
REQ-014 CS  output  2  current state; NS  output  2  next state (combinational).

Function
REQ-015 States SHALL be IDLE=2'b00, SHIFT=2'b01, DONE=2'b10; 2'b11 SHALL decode to IDLE next cycle.
REQ-016 IDLE & Load at edge k SHALL latch Data and effective Len, clear history, enter SHIFT at k+1.
REQ-017 In SHIFT, Out SHALL present Data[Len-1] first, down to Data[0], one bit per cycle, Out_vld=1.
REQ-018 The cycle after the last bit SHALL be DONE: Done=1, Out_vld=0, Out=0.
REQ-019 From DONE: Loop=1 -> SHIFT restarting at Data[Len-1] of held word; Loop=0 -> IDLE.
REQ-020 Load while CS!=IDLE SHALL be ignored; held word and Len unchanged.
REQ-021 Abort in SHIFT or DONE SHALL force IDLE next cycle, no Done; Abort wins over Loop.
REQ-022 A 3-bit history of emitted bits (oldest MSB) SHALL shift on every Out_vld cycle and persist across Loop passes.
REQ-023 Exp_det SHALL equal Out_vld AND history==3'b101 (combinational, same cycle as 4th bit).
REQ-024 Bit counter SHALL count down Len-1..0; SHIFT->DONE when counter is 0.
REQ-025 Single-bit word (Len=1) SHALL produce one SHIFT cycle then DONE.

Reset
REQ-026 Rst=1 SHALL force CS=IDLE, Ready=1, Out=0, Out_vld=0, Done=0, Exp_det=0, history=0, counter=0 at next edge.
REQ-027 Rst SHALL override Load, Abort, Loop, including mid-SHIFT; held word discarded.

Structure
REQ-028 State encodings, WIDTH default and len width SHALL live in shared package seq_det_pkg, used also by the detectors.
REQ-029 Down-counter SHALL be sub-module bit_cnt_dn (load, decrement, zero flag); FSM, shift register and history stay in top.

Verification
REQ-030 Reset: Rst=1 two cycles -> CS=00, Ready=1, Out=0, Out_vld=0, Done=0.
REQ-031 Load Data=16'h000B, Len=4 at k -> Out 1,0,1,1 at k+1..k+4, Exp_det=1 only at k+4, Done at k+5, Ready at k+6.
REQ-032 Overlap: Data=7'b1010101, Len=7 -> Exp_det at k+4 and k+6 only; Done at k+8.
REQ-033 Loop: Data=4'b1010, Len=4, Loop=1 -> Exp_det at k+4 and second-pass bit 2 (k+7); Loop dropped -> IDLE after next Done.
REQ-034 Load pulse during SHIFT ignored; Abort at k+2 -> IDLE at k+3, no Done, Ready=1.
REQ-035 Len=0 with Data=16'h8001 -> 16 bits, first=1, last=1; Rst at bit 8 -> IDLE next edge, all outputs 0.
